// File: rtl/mul4_rr_sched.sv
// mul4_rr_sched
//
// Round-robin front end for one shared 4x4 unsigned multiplier. The multiplier
// itself sits outside this block and is reached through mul_a/mul_b/mul_out.
// The block picks one requester and registers its operands onto mul_a/mul_b.
// It waits MUL_LAT cycles for the combinational array to settle, then captures
// the product. The product and the requester index go out on a single
// valid/ready response channel.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   req_valid[N_REQ]    : requester i has an operand pair pending
//   req_ready[N_REQ]    : one-hot grant (combinational)
//   req_a/req_b         : operands, requester i at bits [4i+3:4i]
//   mul_a/mul_b         : registered operands to the external multiplier
//   mul_out             : product from the external multiplier
//   rsp_valid/rsp_ready : response handshake
//   rsp_out/rsp_id      : captured product and owning requester index
//   busy                : high while an operation is in MUL or RESP
//   op_count            : completed responses, saturating at 0xFFFF

module mul4_rr_sched #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 1,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [4*N_REQ-1:0]   req_a,
    input  logic [4*N_REQ-1:0]   req_b,
    output logic [3:0]           mul_a,
    output logic [3:0]           mul_b,
    input  logic [7:0]           mul_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_out,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy,
    output logic [15:0]          op_count
);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("mul4_rr_sched: N_REQ must be in 2..8");
    end
    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("mul4_rr_sched: MUL_LAT must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [3:0]      settle_cnt;
    logic [ID_W-1:0] rsp_id_next;
    logic [15:0]     op_cnt_q;

    // Unpack the operand buses so the winner can be selected by index.
    logic [3:0] a_arr [N_REQ];
    logic [3:0] b_arr [N_REQ];
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[4*i +: 4];
        assign b_arr[i] = req_b[4*i +: 4];
    end

    // Round-robin search starting at ptr, wrapping modulo N_REQ.
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;

    // NOTE: every variable written in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((32'(ptr) + 32'(k)) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Arbitration is open in IDLE, and in RESP only when the current
    // response is leaving this cycle (back-to-back acceptance).
    logic arb_en;
    logic accept;

    assign arb_en = !rst && ((state == IDLE) || (state == RESP && rsp_ready));
    assign accept = arb_en && grant_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign op_count = op_cnt_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            settle_cnt  <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_id_next <= '0;
            rsp_valid   <= 1'b0;
            rsp_out     <= '0;
            rsp_id      <= '0;
            busy        <= 1'b0;
            op_cnt_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mul_a       <= a_arr[grant_idx];
                        mul_b       <= b_arr[grant_idx];
                        rsp_id_next <= grant_idx;
                        ptr         <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        settle_cnt  <= 4'(MUL_LAT - 1);
                        state       <= MUL;
                        busy        <= 1'b1;
                    end
                end
                MUL: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        rsp_out   <= mul_out;
                        rsp_id    <= rsp_id_next;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (op_cnt_q != 16'hFFFF) begin
                            op_cnt_q <= op_cnt_q + 16'd1;
                        end
                        if (accept) begin
                            mul_a       <= a_arr[grant_idx];
                            mul_b       <= b_arr[grant_idx];
                            rsp_id_next <= grant_idx;
                            ptr         <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                            settle_cnt  <= 4'(MUL_LAT - 1);
                            state       <= MUL;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul4_rr_sched.sv
// tb_mul4_rr_sched
//
// Directed bench for mul4_rr_sched. dut1 runs with MUL_LAT=1 and an ideal
// multiplier. dut3 runs with MUL_LAT=3 and a multiplier that drives X for two
// cycles after every operand change. Inputs change on the falling edge and
// outputs are sampled on the falling edge or 1 ns after a rising edge.

module tb_mul4_rr_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // dut1: MUL_LAT = 1
    logic [3:0]  req_valid, req_ready;
    logic [15:0] req_a, req_b;
    logic [3:0]  mul_a, mul_b;
    logic [7:0]  mul_out;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_out;
    logic [1:0]  rsp_id;
    logic        busy;
    logic [15:0] op_count;

    // dut3: MUL_LAT = 3
    logic [3:0]  req_valid3, req_ready3;
    logic [15:0] req_a3, req_b3;
    logic [3:0]  mul_a3, mul_b3;
    logic [7:0]  mul_out3;
    logic        rsp_valid3, rsp_ready3;
    logic [7:0]  rsp_out3;
    logic [1:0]  rsp_id3;
    logic        busy3;
    logic [15:0] op_count3;

    int errors = 0;
    int checks = 0;

    mul4_rr_sched #(.N_REQ(4), .MUL_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_id(rsp_id),
        .busy(busy), .op_count(op_count)
    );

    mul4_rr_sched #(.N_REQ(4), .MUL_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3),
        .mul_a(mul_a3), .mul_b(mul_b3), .mul_out(mul_out3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_out(rsp_out3), .rsp_id(rsp_id3),
        .busy(busy3), .op_count(op_count3)
    );

    // Ideal multiplier for dut1.
    assign mul_out = 8'(mul_a) * 8'(mul_b);

    // Slow multiplier for dut3: output is X for two cycles after operands move.
    int         age3 = 100;
    logic [3:0] pa3 = 4'd0;
    logic [3:0] pb3 = 4'd0;
    always @(posedge clk) begin
        #1;
        if (mul_a3 !== pa3 || mul_b3 !== pb3) age3 = 0;
        else if (age3 < 100) age3 = age3 + 1;
        pa3 = mul_a3;
        pb3 = mul_b3;
    end
    assign mul_out3 = (age3 < 2) ? 8'bx : 8'(mul_a3) * 8'(mul_b3);

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = '0;
        req_valid3 = '0;
        req_a      = '0;
        req_b      = '0;
        req_a3     = '0;
        req_b3     = '0;
        rsp_ready  = 1'b1;
        rsp_ready3 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [35:0] obs;
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        @(negedge clk);
        obs = {mul_a, mul_b, rsp_valid, rsp_out, rsp_id, busy, op_count};
        checks++;
        if (obs !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_a[3:0] = 4'd15;
        req_b[3:0] = 4'd15;
        req_valid  = 4'b0001;
        rsp_ready  = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if ({busy, rsp_valid, mul_a, mul_b} !== {1'b1, 1'b0, 4'd15, 4'd15}) begin
            errors++;
            $display("FAIL single_mul_phase: got busy=%b rsp_valid=%b a=%0d b=%0d expected 1 0 15 15",
                     busy, rsp_valid, mul_a, mul_b);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_out, rsp_id} !== {1'b1, 8'hE1, 2'd0}) begin
            errors++;
            $display("FAIL single_resp: got valid=%b out=%h id=%0d expected 1 e1 0",
                     rsp_valid, rsp_out, rsp_id);
        end
        @(negedge clk);
        checks++;
        if ({op_count, rsp_valid, busy} !== {16'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_done: got count=%0d valid=%b busy=%b expected 1 0 0",
                     op_count, rsp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        int         ids [5];
        logic [7:0] prods [5];
        int         when [5];
        int         n;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_a[4*i +: 4] = 4'(i + 1);
            req_b[4*i +: 4] = 4'd3;
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                ids[n]   = int'(rsp_id);
                prods[n] = rsp_out;
                when[n]  = c;
                n++;
            end
        end
        req_valid = '0;
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL rr_count: got %0d responses expected 5", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (ids[i] != i % 4 || prods[i] !== 8'((i % 4 + 1) * 3)) begin
                errors++;
                $display("FAIL rr_resp%0d: got id=%0d prod=%0d expected id=%0d prod=%0d",
                         i, ids[i], prods[i], i % 4, (i % 4 + 1) * 3);
            end
            if (i > 0) begin
                checks++;
                if (when[i] - when[i-1] != 2) begin
                    errors++;
                    $display("FAIL rr_interval%0d: got %0d cycles expected 2", i, when[i] - when[i-1]);
                end
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        req_a[11:8] = 4'd7;
        req_b[11:8] = 4'd9;
        req_valid   = 4'b0100;
        rsp_ready   = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_grant: got %b expected 0100", req_ready);
        end
        @(negedge clk);
        req_a[7:4] = 4'd2;
        req_b[7:4] = 4'd5;
        req_valid  = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_out, rsp_id, req_ready, mul_a, mul_b} !==
                {1'b1, 8'd63, 2'd2, 4'b0000, 4'd7, 4'd9}) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b out=%0d id=%0d ready=%b a=%0d b=%0d expected 1 63 2 0000 7 9",
                         i, rsp_valid, rsp_out, rsp_id, req_ready, mul_a, mul_b);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_grant: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if ({mul_a, mul_b, rsp_valid, busy, op_count} !== {4'd2, 4'd5, 1'b0, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL bp_next_op: got a=%0d b=%0d valid=%b busy=%b count=%0d expected 2 5 0 1 1",
                     mul_a, mul_b, rsp_valid, busy, op_count);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_out, rsp_id} !== {1'b1, 8'd10, 2'd1}) begin
            errors++;
            $display("FAIL bp_next_resp: got valid=%b out=%0d id=%0d expected 1 10 1",
                     rsp_valid, rsp_out, rsp_id);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lat3();
        int edges;
        do_reset();
        @(negedge clk);
        req_a3[3:0] = 4'd5;
        req_b3[3:0] = 4'd6;
        req_valid3  = 4'b0001;
        rsp_ready3  = 1'b0;
        edges = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) req_valid3 = '0;
            if (rsp_valid3 === 1'b1) begin
                edges = k;
                break;
            end
        end
        checks++;
        if (edges != 4) begin
            errors++;
            $display("FAIL lat3_latency: got %0d edges expected 4", edges);
        end
        checks++;
        if ({rsp_out3, rsp_id3} !== {8'd30, 2'd0}) begin
            errors++;
            $display("FAIL lat3_product: got out=%h id=%0d expected 1e 0", rsp_out3, rsp_id3);
        end
        @(negedge clk);
        rsp_ready3 = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [35:0] obs;
        do_reset();
        @(negedge clk);
        req_a[7:4] = 4'd3;
        req_b[7:4] = 4'd4;
        req_valid  = 4'b0010;
        rsp_ready  = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rmid_grant: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        // In MUL now; ptr has moved to 2. Assert reset with req3 and req0 pending.
        rst       = 1'b1;
        req_valid = 4'b1001;
        @(negedge clk);
        obs = {mul_a, mul_b, rsp_valid, rsp_out, rsp_id, busy, op_count};
        checks++;
        if (obs !== 36'h0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rmid_outputs: got %h ready=%b expected 0 0000", obs, req_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rmid_ptr: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        force dut1.op_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut1.op_cnt_q;
        req_a[3:0] = 4'd1;
        req_b[3:0] = 4'd1;
        for (int op = 0; op < 2; op++) begin
            @(negedge clk);
            req_valid = 4'b0001;
            rsp_ready = 1'b1;
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (op_count !== 16'hFFFF) begin
                errors++;
                $display("FAIL sat_op%0d: got %h expected ffff", op, op_count);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_valid3 = '0;
        req_a      = '0;
        req_b      = '0;
        req_a3     = '0;
        req_b3     = '0;
        rsp_ready  = 1'b1;
        rsp_ready3 = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_lat3();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
